remote_req_issue_queue: RTL

//  Buffers remote requests (remote load/store, AMO, icache miss fetch) produced by the LSU in EXE
//  and issues them in order to the network TX endpoint. Enforces an outstanding-request credit limit.

---
 rtl/bsg_vanilla_pkg.sv | 30 +++
 rtl/remote_req_issue_queue_pkg.sv | 12 +
 rtl/remote_req_credit_counter.sv | 35 +++
 rtl/remote_req_issue_queue.sv | 91 +++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types: remote request bundle from LSU to network TX.
// Only the slice of the package needed by the remote request path.
package bsg_vanilla_pkg;

  typedef enum logic [1:0] {
    e_amo_none,
    e_amo_swap,
    e_amo_or,
    e_amo_add
  } amo_type_e;

  typedef struct packed {
    logic       icache_fetch;
    logic       is_unsigned;
    logic       is_byte;
    logic       is_hex;
    logic [4:0] reg_id;
  } load_info_s;

  typedef struct packed {
    logic        write_not_read;
    logic        is_amo_op;
    amo_type_e   amo_type;
    logic [3:0]  mask;
    load_info_s  load_info;
    logic [31:0] data;
    logic [31:0] addr;
  } remote_req_s;

endpackage

// File: rtl/remote_req_issue_queue_pkg.sv
// Sizing helpers for the remote request issue queue.
// Safe clog2 keeps every counter/pointer at least one bit wide.
package remote_req_issue_queue_pkg;

  localparam int rriq_fifo_els_default = 2;
  localparam int rriq_credits_default  = 32;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/remote_req_credit_counter.sv
// Up/down saturating counter of outstanding remote requests.
// Ports: up_i/down_i step the count; count_o, full_o (==max), zero_o.
module remote_req_credit_counter
  import remote_req_issue_queue_pkg::*;
#(
  parameter  int max_val_p = rriq_credits_default,
  localparam int width_lp  = safe_clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o,
  output logic                full_o,
  output logic                zero_o
);

  logic [width_lp-1:0] count_r;

  assign full_o  = (count_r == width_lp'(max_val_p));
  assign zero_o  = (count_r == '0);
  assign count_o = count_r;

  // Simultaneous up and down cancel; both ends saturate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (up_i & ~down_i & ~full_o) begin
      count_r <= count_r + 1'b1;
    end else if (down_i & ~up_i & ~zero_o) begin
      count_r <= count_r - 1'b1;
    end
  end

endmodule

// File: rtl/remote_req_issue_queue.sv
// In-order queue of LSU remote requests toward network TX, credit-limited.
// Ports: remote_req_* (LSU side), out_* (TX side), credit_return_i, credits_used_o, fence_busy_o.
module remote_req_issue_queue
  import bsg_vanilla_pkg::*;
  import remote_req_issue_queue_pkg::*;
#(
  parameter  int fifo_els_p        = rriq_fifo_els_default,
  parameter  int max_out_credits_p = rriq_credits_default,
  localparam int credit_width_lp   = safe_clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  remote_req_s                remote_req_i,
  input  logic                       remote_req_v_i,
  output logic                       remote_req_ready_o,
  output remote_req_s                out_req_o,
  output logic                       out_v_o,
  input  logic                       out_yumi_i,
  input  logic                       credit_return_i,
  output logic [credit_width_lp-1:0] credits_used_o,
  output logic                       fence_busy_o
);

  localparam int ptr_w_lp = safe_clog2(fifo_els_p);
  localparam int cnt_w_lp = safe_clog2(fifo_els_p + 1);

  remote_req_s         mem_r [fifo_els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq;
  logic                deq;
  logic                credit_full;
  logic                credit_zero;
  logic                not_empty;

  // Ready comes from registered count only: no path from out_yumi_i.
  assign not_empty          = (count_r != '0);
  assign remote_req_ready_o = (count_r != cnt_w_lp'(fifo_els_p));
  assign enq                = remote_req_v_i & remote_req_ready_o;
  assign deq                = out_yumi_i & out_v_o;

  assign out_v_o      = not_empty & ~credit_full;
  assign out_req_o    = mem_r[rd_ptr_r];
  assign fence_busy_o = not_empty | ~credit_zero;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
      if (enq & ~deq) count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

  // Payload needs no reset; validity is tracked by count_r.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= remote_req_i;
  end

  remote_req_credit_counter #(
    .max_val_p(max_out_credits_p)
  ) credit_cnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (deq),
    .down_i   (credit_return_i),
    .count_o  (credits_used_o),
    .full_o   (credit_full),
    .zero_o   (credit_zero)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(out_yumi_i & ~out_v_o))
        else $error("rriq: out_yumi_i without out_v_o");
      assert (!(credit_return_i & credit_zero))
        else $error("rriq: credit return with no credits used");
      assert (!(enq & (count_r == cnt_w_lp'(fifo_els_p))))
        else $error("rriq: enqueue while full");
    end
  end
`endif

endmodule
